// File: rtl/hex_to_seven_seg_if.sv
// Display bus between a value source (e.g. the register file) and the
// time-multiplexed seven-segment driver. The master supplies the 16-bit value;
// the slave (the driver) returns the active-low digit enables and segments.
interface hex_to_seven_seg_if;

    logic [15:0] Hex_In;         // value to show, [3:0] is the rightmost digit
    logic        dFourEn;        // leftmost digit enable, active-low
    logic        dThreeEn;       // digit enable for Hex_In[11:8], active-low
    logic        dTwoEn;         // digit enable for Hex_In[7:4], active-low
    logic        dOneEn;         // rightmost digit enable, active-low
    logic [6:0]  Seven_Seg_out;  // {g,f,e,d,c,b,a}, active-low

    // Value source side
    modport master (
        output Hex_In,
        input  dFourEn,
        input  dThreeEn,
        input  dTwoEn,
        input  dOneEn,
        input  Seven_Seg_out
    );

    // Display driver side
    modport slave (
        input  Hex_In,
        output dFourEn,
        output dThreeEn,
        output dTwoEn,
        output dOneEn,
        output Seven_Seg_out
    );

endinterface : hex_to_seven_seg_if

// File: rtl/hex_to_seven_seg.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A refresh counter holds each digit for TICKS_PER_DIGIT cycles; the digit
// select then steps 0->1->2->3->0. Enables and segments are registered
// together on the same edge so a digit never shows its neighbour's pattern.
// Hex_In is not captured: the selected nibble is decoded live every cycle.
module hex_to_seven_seg #(
    parameter int unsigned TICKS_PER_DIGIT = 50000  // legal range 1 .. 2**20
) (
    input  logic                    CLK,
    input  logic                    RST,  // synchronous, active-high
    hex_to_seven_seg_if.slave       bus
);

    // A counter of at least one bit keeps TICKS_PER_DIGIT=1 well formed; in
    // that case the counter is always at its maximum and the scan steps every
    // cycle.
    localparam int unsigned      CNT_W   = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Active-low enable patterns, ordered {dFourEn, dThreeEn, dTwoEn, dOneEn}
    localparam logic [3:0] EN_OFF   = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        DIGIT_ONE   = 2'd0,   // Hex_In[3:0],   rightmost
        DIGIT_TWO   = 2'd1,   // Hex_In[7:4]
        DIGIT_THREE = 2'd2,   // Hex_In[11:8]
        DIGIT_FOUR  = 2'd3    // Hex_In[15:12], leftmost
    } digit_e;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode_hex(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] r_cnt;     // cycles spent on the current digit
    digit_e           r_sel;     // digit presented on the next edge
    logic [3:0]       r_en_n;    // registered enables, active-low
    logic [6:0]       r_seg;     // registered segments, active-low

    logic [3:0]       w_nibble;  // nibble of the currently selected digit
    logic [3:0]       w_en_n;    // enable pattern for the selected digit
    logic             w_wrap;    // last cycle of the current digit

    assign w_wrap = (r_cnt == CNT_MAX);

    // Select the nibble and enable pattern for the digit being scanned
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        w_nibble = bus.Hex_In[3:0];
        w_en_n   = 4'b1110;
        case (r_sel)
            DIGIT_ONE: begin
                w_nibble = bus.Hex_In[3:0];
                w_en_n   = 4'b1110;
            end
            DIGIT_TWO: begin
                w_nibble = bus.Hex_In[7:4];
                w_en_n   = 4'b1101;
            end
            DIGIT_THREE: begin
                w_nibble = bus.Hex_In[11:8];
                w_en_n   = 4'b1011;
            end
            DIGIT_FOUR: begin
                w_nibble = bus.Hex_In[15:12];
                w_en_n   = 4'b0111;
            end
            default: begin
                w_nibble = bus.Hex_In[3:0];
                w_en_n   = 4'b1110;
            end
        endcase
    end

    // Register the display outputs and advance the refresh scan
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values; r_sel feeds the mux above and must not update early.
        if (RST) begin
            r_cnt  <= '0;
            r_sel  <= DIGIT_ONE;
            r_en_n <= EN_OFF;
            r_seg  <= SEG_BLANK;
        end else begin
            r_en_n <= w_en_n;
            r_seg  <= decode_hex(w_nibble);
            if (w_wrap) begin
                r_cnt <= '0;
                r_sel <= digit_e'(r_sel + 2'd1);
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign bus.dFourEn       = r_en_n[3];
    assign bus.dThreeEn      = r_en_n[2];
    assign bus.dTwoEn        = r_en_n[1];
    assign bus.dOneEn        = r_en_n[0];
    assign bus.Seven_Seg_out = r_seg;

endmodule : hex_to_seven_seg

// File: tb/tb_hex_to_seven_seg.sv
// Directed bench for hex_to_seven_seg. Two instances share clock and reset:
// one scanning every 4 cycles, one stepping every cycle for the decode sweep.
module tb_hex_to_seven_seg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hex_to_seven_seg_if bus4 ();
    hex_to_seven_seg_if bus1 ();

    hex_to_seven_seg #(.TICKS_PER_DIGIT(4)) u_dut4 (
        .CLK (clk),
        .RST (rst),
        .bus (bus4.slave)
    );

    hex_to_seven_seg #(.TICKS_PER_DIGIT(1)) u_dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bus1.slave)
    );

    // {dFourEn, dThreeEn, dTwoEn, dOneEn}
    logic [3:0] en4;
    logic [3:0] en1;
    assign en4 = {bus4.dFourEn, bus4.dThreeEn, bus4.dTwoEn, bus4.dOneEn};
    assign en1 = {bus1.dFourEn, bus1.dThreeEn, bus1.dTwoEn, bus1.dOneEn};

    // Hand-written decode table, index = hex digit
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};
    // Active-low enable pattern per digit index
    logic [3:0] en_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] scan_seg [4];
        bus4.Hex_In = 16'h0000;
        bus1.Hex_In = 16'h0000;

        // ---- Reset and first edge after release ----
        bus4.Hex_In = 16'h00A5;
        do_reset(2);
        check("rst_en",  32'(en4), 32'h0F);
        check("rst_seg", 32'(bus4.Seven_Seg_out), 32'h7F);
        tick();
        check("rel_en",  32'(en4), 32'hE);
        check("rel_seg", 32'(bus4.Seven_Seg_out), 32'h12);  // digit 5

        // ---- Full scan, 4 ticks per digit, 0x1234 ----
        scan_seg = '{7'h19, 7'h30, 7'h24, 7'h79};  // 4, 3, 2, 1
        bus4.Hex_In = 16'h1234;
        do_reset(2);
        for (int c = 1; c <= 17; c++) begin
            tick();
            check($sformatf("scan_en_c%0d", c),  32'(en4), 32'(en_tbl[((c - 1) / 4) % 4]));
            check($sformatf("scan_seg_c%0d", c), 32'(bus4.Seven_Seg_out), 32'(scan_seg[((c - 1) / 4) % 4]));
        end

        // ---- Decode sweep, 1 tick per digit ----
        do_reset(2);
        for (int v = 0; v < 16; v++) begin
            bus1.Hex_In = 16'(v * 16'h1111);
            for (int d = 0; d < 4; d++) begin
                tick();
                check($sformatf("sweep_seg_v%0h_d%0d", v, d), 32'(bus1.Seven_Seg_out), 32'(seg_tbl[v]));
                check($sformatf("sweep_en_v%0h_d%0d", v, d),  32'(en1), 32'(en_tbl[d]));
            end
        end

        // ---- Live update while dOneEn is low ----
        bus4.Hex_In = 16'h00FF;
        do_reset(2);
        tick();
        check("live_seg0", 32'(bus4.Seven_Seg_out), 32'h0E);
        check("live_en0",  32'(en4), 32'hE);
        bus4.Hex_In = 16'h00F0;
        tick();
        check("live_seg1", 32'(bus4.Seven_Seg_out), 32'h40);
        check("live_en1",  32'(en4), 32'hE);

        // ---- Mid-scan reset while dThreeEn is low ----
        bus4.Hex_In = 16'h1234;
        do_reset(2);
        repeat (9) tick();
        check("mid_pre_en",  32'(en4), 32'hB);
        check("mid_pre_seg", 32'(bus4.Seven_Seg_out), 32'h24);
        rst = 1'b1;
        tick();
        check("mid_rst_en",  32'(en4), 32'hF);
        check("mid_rst_seg", 32'(bus4.Seven_Seg_out), 32'h7F);
        rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("mid_post_en_c%0d", c), 32'(en4), (c <= 4) ? 32'hE : 32'hD);
        end

        // ---- One-hot enables under random data ----
        for (int c = 0; c < 1000; c++) begin
            bus4.Hex_In = 16'($urandom);
            bus1.Hex_In = 16'($urandom);
            tick();
            check("onehot4", 32'($countones(~en4)), 32'd1);
            check("onehot1", 32'($countones(~en1)), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hex_to_seven_seg
